// File: rtl/field_register_bank.sv
// field_register_bank: double-buffered settings registers with staged writes and atomic commit/revert.
// Optional FIELD_BCD_CHECK_EN rejects writes whose data holds a non-BCD nibble.
module field_register_bank #(
  parameter int WIDTH = 8,
  parameter int NUM_FIELDS = 9,
  parameter int ADDR_W = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic                        wr_err,
  input  logic                        commit_req,
  input  logic                        revert_req,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_FIELDS-1:0]       dirty,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [WIDTH-1:0]            rd_data,
  output logic [NUM_FIELDS*WIDTH-1:0] data_out
);
  typedef enum logic [1:0] {IDLE, COMMIT, REVERT, DONE} state_t;
  localparam logic [ADDR_W:0] NF = (ADDR_W+1)'(NUM_FIELDS);
  state_t state;
  logic [NUM_FIELDS-1:0][WIDTH-1:0] staging, active;
  logic legal, in_range, accept;
`ifdef FIELD_BCD_CHECK_EN
  always_comb begin
    legal = 1'b1;
    for (int i = 0; i < WIDTH/4; i++) legal = legal && (wr_data[i*4 +: 4] <= 4'd9);
  end
`else
  assign legal = 1'b1;
`endif
  assign in_range = {1'b0, wr_addr} < NF;
  assign accept = wr_valid && state == IDLE;
  assign wr_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign data_out = active;
  assign rd_data = ({1'b0, rd_addr} < NF) ? staging[rd_addr] : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      staging <= {NUM_FIELDS{RESET_VAL}};
      active <= {NUM_FIELDS{RESET_VAL}};
      dirty <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= accept && !(in_range && legal);
      case (state)
        IDLE: begin
          if (accept && in_range && legal) begin
            staging[wr_addr] <= wr_data;
            dirty[wr_addr] <= 1'b1;
          end
          state <= commit_req ? COMMIT : revert_req ? REVERT : IDLE;
        end
        COMMIT: begin
          active <= staging;
          dirty <= '0;
          state <= DONE;
        end
        REVERT: begin
          staging <= active;
          dirty <= '0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_field_register_bank.sv
// tb_field_register_bank: directed steps with a scoreboard of expected data_out after each commit/revert.
module tb_field_register_bank;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic wr_valid = 0, commit_req = 0, revert_req = 0;
  logic [3:0] wr_addr = 0, rd_addr = 0;
  logic [7:0] wr_data = 0;
  logic wr_ready, wr_err, busy, done;
  logic [8:0] dirty;
  logic [7:0] rd_data;
  logic [71:0] data_out;
  logic v2 = 0, c2 = 0, rv2 = 0;
  logic [1:0] a2 = 0, r2 = 0;
  logic [15:0] d2 = 0;
  logic rdy2, err2, busy2, done2;
  logic [2:0] dirty2;
  logic [15:0] rd2;
  logic [47:0] out2;
  int n_chk = 0, n_fail = 0;
  logic [8:0][7:0] stg = '0, act = '0;
  logic [8:0] mdirty = '0;
  logic [71:0] sb[$];

  field_register_bank dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err), .commit_req(commit_req), .revert_req(revert_req),
    .busy(busy), .done(done), .dirty(dirty), .rd_addr(rd_addr), .rd_data(rd_data), .data_out(data_out)
  );

  field_register_bank #(.WIDTH(16), .NUM_FIELDS(3), .ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .wr_valid(v2), .wr_ready(rdy2), .wr_addr(a2),
    .wr_data(d2), .wr_err(err2), .commit_req(c2), .revert_req(rv2),
    .busy(busy2), .done(done2), .dirty(dirty2), .rd_addr(r2), .rd_data(rd2), .data_out(out2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ok(input logic [7:0] d);
`ifdef FIELD_BCD_CHECK_EN
    return d[7:4] <= 4'd9 && d[3:0] <= 4'd9;
`else
    return 1'b1;
`endif
  endfunction

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bit good;
    good = a < 9 && ok(d);
    wr_valid = 1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 0;
    if (good) begin
      stg[a] = d;
      mdirty[a] = 1'b1;
    end
    chk("wr_err", wr_err, !good);
  endtask

  // Caller may have a write and/or revert_req already driven for the sampling edge.
  task automatic seq(input bit commit);
    if (commit) commit_req = 1; else revert_req = 1;
    sb.push_back(commit ? stg : act);
    tick();
    commit_req = 0; revert_req = 0; wr_valid = 0;
    chk("busy", busy, 1);
    chk("wr_ready_busy", wr_ready, 0);
    tick();
    if (commit) act = stg; else stg = act;
    mdirty = '0;
    chk("done", done, 1);
    chk("data_out", data_out, sb.pop_front());
    chk("dirty_clr", dirty, 0);
    tick();
    chk("done_end", done, 0);
    chk("wr_ready_idle", wr_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 reset = 0;
    #2;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_data_out", data_out, 0);
    @(negedge clk) reset = 1;
    tick();
    // staging isolation then commit
    wr(3, 8'h23);
    wr(4, 8'h59);
    rd_addr = 3; #1 chk("rd_f3", rd_data, 8'h23);
    rd_addr = 4; #1 chk("rd_f4", rd_data, 8'h59);
    chk("dirty_34", dirty, 9'h018);
    chk("isolated", data_out, 0);
    seq(1);
    chk("f3_active", data_out[31:24], 8'h23);
    chk("f4_active", data_out[39:32], 8'h59);
    // revert discards staged edit
    wr(0, 8'h05);
    seq(1);
    wr(0, 8'h12);
    rd_addr = 0; #1 chk("rd_staged", rd_data, 8'h12);
    seq(0);
    rd_addr = 0; #1 chk("rd_reverted", rd_data, 8'h05);
    chk("f0_kept", data_out[7:0], 8'h05);
    // commit beats revert and includes same-edge write
    wr_valid = 1; wr_addr = 2; wr_data = 8'h47;
    stg[2] = 8'h47;
    revert_req = 1;
    seq(1);
    chk("f2_same_edge", data_out[23:16], 8'h47);
    // write held across busy is accepted in first IDLE cycle
    commit_req = 1;
    sb.push_back(stg);
    tick();
    commit_req = 0;
    wr_valid = 1; wr_addr = 5; wr_data = 8'h31;
    chk("hold_rdy1", wr_ready, 0);
    tick();
    act = stg;
    chk("hold_rdy2", wr_ready, 0);
    chk("hold_data_out", data_out, sb.pop_front());
    chk("hold_dirty", dirty, 0);
    tick();
    chk("hold_rdy3", wr_ready, 1);
    chk("hold_not_yet", dirty, 0);
    tick();
    wr_valid = 0;
    stg[5] = 8'h31; mdirty[5] = 1'b1;
    chk("hold_accepted", dirty, mdirty);
    rd_addr = 5; #1 chk("rd_f5", rd_data, 8'h31);
    chk("f5_inactive", data_out[47:40], 8'h00);
    // out-of-range address
    wr(12, 8'h77);
    chk("oor_dirty", dirty, mdirty);
    tick();
    chk("wr_err_pulse", wr_err, 0);
    rd_addr = 12; #1 chk("rd_oor", rd_data, 0);
    // non-BCD data: stored unless the check is enabled
    wr(1, 8'h3A);
    rd_addr = 1; #1 chk("rd_3a", rd_data, stg[1]);
    chk("dirty_3a", dirty, mdirty);
    // asynchronous reset in the middle of a commit
    commit_req = 1;
    tick();
    commit_req = 0;
    chk("mid_busy", busy, 1);
    reset = 0;
    #1;
    chk("mid_data_out", data_out, 0);
    chk("mid_dirty", dirty, 0);
    chk("mid_busy_clr", busy, 0);
    chk("mid_wr_ready", wr_ready, 1);
    rd_addr = 3; #1 chk("mid_staging", rd_data, 0);
    reset = 1;
    tick();
    // wide/narrow parameter set
    v2 = 1; a2 = 2; d2 = 16'h1234;
    tick();
    v2 = 0;
    chk("p2_dirty", dirty2, 3'b100);
    r2 = 2; #1 chk("p2_rd", rd2, 16'h1234);
    c2 = 1;
    tick();
    c2 = 0;
    tick();
    chk("p2_f2", out2[47:32], 16'h1234);
    chk("p2_low", out2[31:0], 0);
    tick();
    v2 = 1; a2 = 3; d2 = 16'h0001;
    tick();
    v2 = 0;
    chk("p2_err", err2, 1);
    chk("p2_err_dirty", dirty2, 0);
    tick();
    chk("p2_err_end", err2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
